// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS control path
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    // ALU Ctrl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_LW  = 3'b001;
    localparam logic [2:0] ALU_SW  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_BEQ = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;

    // ALU In1 selects
    localparam logic [1:0] SRC_A_PC   = 2'b00;
    localparam logic [1:0] SRC_A_REGA = 2'b01;
    localparam logic [1:0] SRC_A_REGB = 2'b10;

    // ALU In2 selects
    localparam logic [2:0] SRC_B_REGB    = 3'b000;
    localparam logic [2:0] SRC_B_FOUR    = 3'b001;
    localparam logic [2:0] SRC_B_IMM     = 3'b010;
    localparam logic [2:0] SRC_B_IMM_SH2 = 3'b011;
    localparam logic [2:0] SRC_B_SHAMT   = 3'b100;

    // PC sources
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - ALU Ctrl selection and instruction legality check
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  state_t     state,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    logic [2:0] funct_ctrl;
    logic       funct_legal;

    // Map the R-type funct field onto an ALU operation
    always_comb begin
        funct_ctrl  = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_ADD:  funct_ctrl = ALU_ADD;
            FN_AND:  funct_ctrl = ALU_AND;
            FN_NOR:  funct_ctrl = ALU_NOR;
            FN_SLT:  funct_ctrl = ALU_SLT;
            FN_SLL:  funct_ctrl = ALU_SLL;
            default: funct_legal = 1'b0;
        endcase
    end

    // Opcode legality; R-type is only legal with a supported funct
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE:                 legal = funct_legal;
            OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
            default:                  legal = 1'b0;
        endcase
    end

    // ALU operation depends on which step of the instruction is running
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (state)
            S_MEM_ADDR: alu_ctrl = (opcode == OP_SW) ? ALU_SW : ALU_LW;
            S_EXEC_R:   alu_ctrl = funct_ctrl;
            S_BRANCH:   alu_ctrl = ALU_BEQ;
            default:    alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] dec_alu_ctrl;
    logic       dec_legal;

    mips_alu_decode u_alu_decode (
        .opcode   (opcode),
        .funct    (funct),
        .state    (state_q),
        .alu_ctrl (dec_alu_ctrl),
        .legal    (dec_legal)
    );

    // State register; reset always lands on FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = reset ? 4'd0 : state_q;

    // Next-state and strobe decode; everything is held low during reset so an
    // abandoned instruction cannot write anything in the reset cycle
    always_comb begin
        state_d    = S_FETCH;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PC_SRC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_REGB;
        alu_ctrl   = ALU_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_FOUR;
                    alu_ctrl  = dec_alu_ctrl;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = PC_SRC_ALU;
                        state_d   = S_DECODE;
                    end else begin
                        state_d   = S_FETCH;
                    end
                end

                S_DECODE: begin
                    // Branch target is computed speculatively into ALUOut
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_IMM_SH2;
                    alu_ctrl  = dec_alu_ctrl;
                    if (!dec_legal) begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end else if (is_mem_op(opcode)) begin
                        state_d = S_MEM_ADDR;
                    end else if (opcode == OP_RTYPE) begin
                        state_d = S_EXEC_R;
                    end else if (opcode == OP_BEQ) begin
                        state_d = S_BRANCH;
                    end else begin
                        state_d = S_JUMP;
                    end
                end

                S_MEM_ADDR: begin
                    alu_src_a = SRC_A_REGA;
                    alu_src_b = SRC_B_IMM;
                    alu_ctrl  = dec_alu_ctrl;
                    state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                end

                S_MEM_READ: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
                end

                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b0;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end

                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d    = S_MEM_WRITE;
                    end
                end

                S_EXEC_R: begin
                    alu_ctrl = dec_alu_ctrl;
                    // sll shifts rt by shamt, so both operands change source
                    if (funct == FN_SLL) begin
                        alu_src_a = SRC_A_REGB;
                        alu_src_b = SRC_B_SHAMT;
                    end else begin
                        alu_src_a = SRC_A_REGA;
                        alu_src_b = SRC_B_REGB;
                    end
                    state_d = S_R_WB;
                end

                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    mem_to_reg = 1'b0;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end

                S_BRANCH: begin
                    alu_src_a  = SRC_A_REGA;
                    alu_src_b  = SRC_B_REGB;
                    alu_ctrl   = dec_alu_ctrl;
                    pc_source  = PC_SRC_ALUOUT;
                    pc_write   = alu_zero;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end

                S_JUMP: begin
                    pc_source  = PC_SRC_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_source;
    logic       reg_write, reg_dst, mem_to_reg;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b, alu_ctrl;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       rd;
        logic       wr;
        logic       io;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic [1:0] sa;
        logic [2:0] sb;
        logic [2:0] alu;
        logic       done;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        exp_t       e;
    } step_t;

    step_t stim[$];
    exp_t  sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t e(input int st, input int rd, input int wr, input int io,
                               input int irw, input int pcw, input int pcs, input int rw,
                               input int rdst, input int m2r, input int sa, input int sb,
                               input int alu, input int done, input int ill);
        exp_t x;
        x.st = st[3:0];  x.rd = rd[0];   x.wr = wr[0];     x.io = io[0];
        x.irw = irw[0];  x.pcw = pcw[0]; x.pcs = pcs[1:0]; x.rw = rw[0];
        x.rdst = rdst[0]; x.m2r = m2r[0]; x.sa = sa[1:0];  x.sb = sb[2:0];
        x.alu = alu[2:0]; x.done = done[0]; x.ill = ill[0];
        return x;
    endfunction

    task automatic add(input int rst, input int op, input int fn, input int z, input int rdy,
                       input exp_t x);
        step_t s;
        s.rst = rst[0]; s.op = op[5:0]; s.fn = fn[5:0]; s.z = z[0]; s.rdy = rdy[0]; s.e = x;
        stim.push_back(s);
    endtask

    // Monitor: pop one expected vector per driven cycle and compare away from the edge
    always @(negedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            exp_t x;
            string p;
            x = sb_q.pop_front();
            cyc++;
            p = $sformatf("c%0d.", cyc);
            check_eq({p, "state"},      32'(state),      32'(x.st));
            check_eq({p, "mem_read"},   32'(mem_read),   32'(x.rd));
            check_eq({p, "mem_write"},  32'(mem_write),  32'(x.wr));
            check_eq({p, "iord"},       32'(iord),       32'(x.io));
            check_eq({p, "ir_write"},   32'(ir_write),   32'(x.irw));
            check_eq({p, "pc_write"},   32'(pc_write),   32'(x.pcw));
            check_eq({p, "pc_source"},  32'(pc_source),  32'(x.pcs));
            check_eq({p, "reg_write"},  32'(reg_write),  32'(x.rw));
            check_eq({p, "reg_dst"},    32'(reg_dst),    32'(x.rdst));
            check_eq({p, "mem_to_reg"}, 32'(mem_to_reg), 32'(x.m2r));
            check_eq({p, "alu_src_a"},  32'(alu_src_a),  32'(x.sa));
            check_eq({p, "alu_src_b"},  32'(alu_src_b),  32'(x.sb));
            check_eq({p, "alu_ctrl"},   32'(alu_ctrl),   32'(x.alu));
            check_eq({p, "instr_done"}, 32'(instr_done), 32'(x.done));
            check_eq({p, "illegal_op"}, 32'(illegal_op), 32'(x.ill));
            check_eq({p, "excl_mem"},   32'(mem_read & mem_write), 32'd0);
            check_eq({p, "excl_wr"},    32'(reg_write & pc_write), 32'd0);
        end
    end

    initial begin
        exp_t zero_v, fetch_go, fetch_wait, decode_v;
        //               st rd wr io irw pcw pcs rw rdst m2r sa sb alu done ill
        zero_v     = e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fetch_go   = e(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        fetch_wait = e(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        decode_v   = e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);

        // Reset held two cycles
        add(1, 'h00, 'h2A, 0, 1, zero_v);
        add(1, 'h00, 'h2A, 0, 1, zero_v);
        // slt: 0,1,6,7
        add(0, 'h00, 'h2A, 0, 1, fetch_go);
        add(0, 'h00, 'h2A, 0, 1, decode_v);
        add(0, 'h00, 'h2A, 0, 1, e(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0));
        add(0, 'h00, 'h2A, 0, 1, e(7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
        // sll
        add(0, 'h00, 'h00, 0, 1, fetch_go);
        add(0, 'h00, 'h00, 0, 1, decode_v);
        add(0, 'h00, 'h00, 0, 1, e(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 4, 5, 0, 0));
        add(0, 'h00, 'h00, 0, 1, e(7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
        // nor, mem_ready low outside memory states is ignored
        add(0, 'h00, 'h27, 0, 1, fetch_go);
        add(0, 'h00, 'h27, 0, 0, decode_v);
        add(0, 'h00, 'h27, 0, 0, e(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0));
        add(0, 'h00, 'h27, 0, 0, e(7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
        // lw with three wait cycles in MEM_READ: 8 cycles total
        add(0, 'h23, 'h11, 0, 1, fetch_go);
        add(0, 'h23, 'h11, 0, 1, decode_v);
        add(0, 'h23, 'h11, 0, 1, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
        add(0, 'h23, 'h11, 0, 0, e(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 'h23, 'h11, 0, 0, e(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 'h23, 'h11, 0, 0, e(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 'h23, 'h11, 0, 1, e(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 'h23, 'h11, 0, 1, e(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
        // beq taken
        add(0, 'h04, 'h11, 1, 1, fetch_go);
        add(0, 'h04, 'h11, 1, 1, decode_v);
        add(0, 'h04, 'h11, 1, 1, e(8, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 6, 1, 0));
        // beq not taken
        add(0, 'h04, 'h11, 0, 1, fetch_go);
        add(0, 'h04, 'h11, 0, 1, decode_v);
        add(0, 'h04, 'h11, 0, 1, e(8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 6, 1, 0));
        // illegal opcode, then jump
        add(0, 'h3F, 'h11, 0, 1, fetch_go);
        add(0, 'h3F, 'h11, 0, 1, e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1));
        add(0, 'h02, 'h11, 0, 1, fetch_go);
        add(0, 'h02, 'h11, 0, 1, decode_v);
        add(0, 'h02, 'h11, 0, 1, e(9, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0));
        // R-type with unsupported funct
        add(0, 'h00, 'h21, 0, 1, fetch_go);
        add(0, 'h00, 'h21, 0, 1, e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1));
        // sw with a fetch wait and one write wait
        add(0, 'h2B, 'h11, 0, 0, fetch_wait);
        add(0, 'h2B, 'h11, 0, 1, fetch_go);
        add(0, 'h2B, 'h11, 0, 1, decode_v);
        add(0, 'h2B, 'h11, 0, 1, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0));
        add(0, 'h2B, 'h11, 0, 0, e(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 'h2B, 'h11, 0, 1, e(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // sw abandoned by reset while waiting in MEM_WRITE
        add(0, 'h2B, 'h11, 0, 1, fetch_go);
        add(0, 'h2B, 'h11, 0, 1, decode_v);
        add(0, 'h2B, 'h11, 0, 1, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0));
        add(0, 'h2B, 'h11, 0, 0, e(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(1, 'h2B, 'h11, 0, 0, zero_v);
        add(0, 'h2B, 'h11, 0, 0, fetch_wait);
        add(0, 'h2B, 'h11, 0, 1, fetch_go);

        foreach (stim[i]) begin
            @(negedge clk);
            reset     = stim[i].rst;
            opcode    = stim[i].op;
            funct     = stim[i].fn;
            alu_zero  = stim[i].z;
            mem_ready = stim[i].rdy;
            sb_q.push_back(stim[i].e);
        end
        @(negedge clk);
        #4;
        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check_eq("cycles_compared", 32'(cyc), 32'(stim.size()));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS control FSM that sequences the shared 32-bit ALU, register file, PC and unified memory through fetch, decode, execute, memory and writeback.
- Drives the ALU's 3-bit Ctrl encoding, operand-mux selects and all datapath write strobes.
- Handshakes with a variable-latency memory through mem_ready.
- Sits between the instruction register fields and the datapath; one instruction is in flight at a time.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word
- OP_SW, 6'h2B, store word
- OP_BEQ, 6'h04, branch if equal
- OP_J, 6'h02, jump

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU Zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  load IR from memory data
- pc_write  out  1  load PC (unconditional, or branch already resolved)
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- reg_write  out  1  register file write enable
- reg_dst  out  1  destination register: 0=rt, 1=rd
- mem_to_reg  out  1  writeback source: 0=ALUOut, 1=MDR
- alu_src_a  out  2  ALU In1: 00=PC, 01=regA, 10=regB
- alu_src_b  out  3  ALU In2: 000=regB, 001=const 4, 010=sign-ext imm, 011=sign-ext imm<<2, 100=zero-ext shamt
- alu_ctrl  out  3  ALU Ctrl: add=000, lw=001, sw=010, and=011, nor=100, sll=101, beq=110, slt=111
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode or funct
- state  out  4  current state, for debug

Behaviour:
- Encoding: state register 4 bits. FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9.
- Output style: outputs are a combinational decode of the state, the IR fields and mem_ready.
- Reset cycle: while reset=1, every output is forced to 0 (alu_ctrl=000, state=0).
- Reset effect: next state is FETCH. Reset mid-instruction abandons it with no write strobe in that cycle.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=001, alu_ctrl=add.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_source=00, go to DECODE.
  - Else: hold in FETCH, ir_write=0, pc_write=0.
- DECODE: alu_src_a=00, alu_src_b=011, alu_ctrl=add (branch target into ALUOut).
  - lw or sw -> MEM_ADDR
  - R-type with a legal funct -> EXEC_R
  - beq -> BRANCH
  - j -> JUMP
  - anything else: illegal_op=1 for one cycle, go to FETCH, no retire.
- MEM_ADDR: alu_src_a=01, alu_src_b=010, alu_ctrl=001 for lw or 010 for sw. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Wait until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1, go to FETCH.
- MEM_WRITE: mem_write=1, iord=1, held until mem_ready=1. On that cycle: instr_done=1, go to FETCH.
- EXEC_R, legal funct: add=0x20, and=0x24, nor=0x27, slt=0x2A, sll=0x00.
- EXEC_R, non-sll: alu_src_a=01, alu_src_b=000, alu_ctrl from funct.
- EXEC_R, sll: alu_src_a=10, alu_src_b=100, alu_ctrl=101. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1, go to FETCH.
- BRANCH: alu_src_a=01, alu_src_b=000, alu_ctrl=110, pc_source=01, pc_write=alu_zero, instr_done=1, go to FETCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1, go to FETCH.
- Minimum latencies with mem_ready tied to 1: lw 5 cycles, sw 4, R-type 4, beq 3, j 3. Every wait cycle on mem_ready adds 1.
- Strobe exclusivity: mem_read and mem_write are never both 1. reg_write and pc_write are never both 1.
- mem_ready outside a memory state is ignored.
- Unused encodings 10–15 go to FETCH on the next edge with all outputs 0.

Decomposition:
- Shared package mips_pkg holds:
  - state encodings
  - ALU Ctrl codes (000–111 as listed)
  - opcode and funct constants
  - alu_src_a and alu_src_b select codes
- One sub-module, mips_alu_decode: combinational (opcode, funct, state) -> alu_ctrl plus a legal flag, reused by the FSM.

Test Plan:
- Reset: reset=1 for 2 cycles, then release with mem_ready=1 -> state=0 and all outputs 0 during reset; ir_write=1 and pc_write=1 on the first cycle after release.
- R-type: opcode=0x00, funct=0x2A, mem_ready=1 -> states 0,1,6,7; alu_ctrl=111 in EXEC_R; reg_write=1 and reg_dst=1 and instr_done=1 in cycle 4. Repeat with funct=0x00 -> alu_ctrl=101, alu_src_a=10, alu_src_b=100.
- Load with wait states: opcode=0x23, mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles, iord=1 throughout; MEM_WB gives reg_write=1, mem_to_reg=1; total 8 cycles.
- Branch: opcode=0x04 with alu_zero=1 -> pc_write=1, pc_source=01 in BRANCH. Repeat with alu_zero=0 -> pc_write=0, instr_done=1, next state FETCH.
- Illegal and jump: opcode=0x3F -> illegal_op pulse in DECODE, no reg_write or mem_write, back to FETCH. Then opcode=0x02 -> pc_source=10, pc_write=1 in JUMP.
- Reset mid-op: assert reset during MEM_WRITE with mem_ready=0 -> mem_write drops the same cycle; state=FETCH after the edge; no instr_done.
